// File: rtl/d4_serial_pkg.sv
// Shared types and defaults for the serial transmit/receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package d4_serial_pkg;

   typedef enum logic [1:0] {IDLE, SEND, DONE} tx_state_t;

   // Defaults shared with the receive-side shift_register benches.
   localparam int DEF_WIDTH        = 8;
   localparam int DEF_CLKS_PER_BIT = 1;

endpackage

// File: rtl/bit_period_counter.sv
// Counts clocks within one bit period and flags the last clock of the period.
// Latency: tick is combinational from the count; count restarts the cycle after tick.
// Backpressure: none; held at zero while clear is high.
module bit_period_counter #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clk,
   input  logic n_reset,
   input  logic clear,
   output logic tick
);

   localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_cnt;

   // With one clock per bit the count never leaves zero and every cycle ticks.
   assign tick = (r_cnt == LAST);

   // Period count: zero while idle, wraps to zero after the terminal clock.
   always_ff @(posedge clk) begin
      if (!n_reset || clear) begin
         r_cnt <= '0;
      end else if (tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/serial_transmitter.sv
// Parallel-in serial-out transmitter: sends an n-bit word one bit per CLKS_PER_BIT clocks.
// Latency: bit 0 appears the cycle after acceptance; done at n*CLKS_PER_BIT+1.
// Backpressure: tx_ready only in IDLE; requests while busy are dropped, not queued.
module serial_transmitter
   import d4_serial_pkg::*;
#(
   parameter int n            = DEF_WIDTH,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter bit MSB_FIRST    = 1'b1
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic [n-1:0] pdatain,
   input  logic         tx_valid,
   output logic         tx_ready,
   output logic         sdataout,
   output logic         sstrobe,
   output logic         busy,
   output logic         done
);

   localparam int               BIT_W    = $clog2(n);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(n - 1);

   tx_state_t        r_state;
   tx_state_t        w_state_nxt;
   logic [n-1:0]     r_shift;
   logic [BIT_W-1:0] r_bit_cnt;
   logic             w_tick;
   logic             w_clear;
   logic             w_accept;
   logic             w_last;

   // Ready is gated by reset so nothing is accepted while reset is held.
   assign tx_ready = (r_state == IDLE) && n_reset;
   assign w_accept = tx_valid && tx_ready;
   assign w_clear  = (r_state != SEND);
   assign w_last   = (r_bit_cnt == LAST_BIT) && w_tick;

   bit_period_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_period (
      .clk     (clk),
      .n_reset (n_reset),
      .clear   (w_clear),
      .tick    (w_tick)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and output decode; outputs are quiet outside SEND/DONE.
   always_comb begin
      w_state_nxt = r_state;
      sdataout    = 1'b0;
      sstrobe     = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = SEND;
            end
         end
         SEND: begin
            sdataout = MSB_FIRST ? r_shift[n-1] : r_shift[0];
            sstrobe  = w_tick;
            busy     = 1'b1;
            if (w_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Holding register and bit counter: load on accept, advance one bit per period.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else if (w_accept) begin
         r_shift   <= pdatain;
         r_bit_cnt <= '0;
      end else if ((r_state == SEND) && w_tick) begin
         if (MSB_FIRST) begin
            r_shift <= {r_shift[n-2:0], 1'b0};
         end else begin
            r_shift <= {1'b0, r_shift[n-1:1]};
         end
         r_bit_cnt <= w_last ? '0 : (r_bit_cnt + BIT_W'(1));
      end
   end

endmodule

// File: doc/serial_transmitter.md
Name: serial_transmitter

Overview:
- Parallel-in, serial-out transmitter. It is the sending end for the shift_register serial-in/parallel-out path.
- Accepts an n-bit word through a valid/ready handshake, then emits it one bit at a time on sdataout.
- Raises sstrobe once per bit, in the cycle the receiver must sample. Driving a shift_register with shift = sstrobe and sdatain = sdataout delivers the word on its pdataout.

Parameters:
- n, 8, data word width in bits; n >= 2.
- CLKS_PER_BIT, 1, clock cycles each bit is held on sdataout; CLKS_PER_BIT >= 1.
- MSB_FIRST, 1, 1 = bit n-1 sent first; 0 = bit 0 sent first.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- n_reset  input  1  synchronous active-low reset.
- pdatain  input  n  word to transmit; sampled only on acceptance.
- tx_valid  input  1  requester has a word on pdatain.
- tx_ready  output  1  block can accept a word this cycle.
- sdataout  output  1  serial data bit.
- sstrobe  output  1  one-cycle pulse: sdataout is valid to sample.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse after the last bit.

Behaviour:
- Reset and clocking:
  - One clock. Reset is synchronous and active-low, sampled on the clk rising edge; no asynchronous paths.
  - On reset: state IDLE, sdataout = 0, sstrobe = 0, busy = 0, done = 0, shift/bit/period counters = 0.
  - tx_ready = (state == IDLE) && n_reset, combinational; it is therefore 0 during reset.
- FSM states:
  - IDLE: sdataout = 0. On tx_valid && tx_ready at an edge: latch pdatain into the holding register, bit_cnt = 0, period_cnt = 0, go to SEND.
  - SEND: sdataout = current bit (MSB or LSB of the holding register per MSB_FIRST). busy = 1. period_cnt counts 0..CLKS_PER_BIT-1.
    - sstrobe = 1 exactly when period_cnt == CLKS_PER_BIT-1.
    - On that cycle's edge: shift the holding register by one, bit_cnt += 1, period_cnt = 0.
    - When bit_cnt == n-1 and period_cnt == CLKS_PER_BIT-1, go to DONE.
  - DONE: one cycle; done = 1, busy = 0, sdataout = 0, sstrobe = 0. Then go to IDLE.
- Timing, with acceptance at edge E0:
  - Bit k occupies cycles k*C+1 .. (k+1)*C after E0; its sstrobe is in cycle (k+1)*C.
  - done is in cycle n*C+1. tx_ready returns in cycle n*C+2.
  - Minimum spacing between accepted words is n*C+2 cycles.
- Handshake rules:
  - tx_valid while tx_ready = 0 is ignored and not queued.
  - Changes to pdatain after acceptance have no effect on the frame.
  - Holding tx_valid high continuously sends back-to-back frames, each separated by the DONE and IDLE cycles.
- Counter widths: bit_cnt is $clog2(n) bits; period_cnt is max(1, $clog2(CLKS_PER_BIT)) bits. No wrap before terminal count.
- Boundary cases:
  - CLKS_PER_BIT = 1: sstrobe stays high for all n SEND cycles.
  - Reset asserted mid-frame: at the next edge everything returns to reset values, the frame is abandoned, and no done pulse is produced.
  - tx_valid asserted together with reset deassertion: not accepted, since tx_ready = 0 in that cycle. Acceptance is possible from the following cycle.

Decomposition:
- Package d4_serial_pkg holds:
  - typedef enum logic [1:0] {IDLE, SEND, DONE} tx_state_t;
  - localparam defaults for word width (8) and CLKS_PER_BIT (1), shared with the receive-side shift_register benches.
- Sub-module bit_period_counter (parameter CLKS_PER_BIT; ports clk, n_reset, clear, tick): generates the end-of-period tick that drives sstrobe and the shift.
- The FSM, holding register and bit counter stay in serial_transmitter.

Test Plan:
- Basic frame: n = 8, C = 1, MSB_FIRST = 1, pdatain = 8'b11001100, tx_valid pulsed for one cycle.
  -> sdataout = 1,1,0,0,1,1,0,0 on cycles 1..8; sstrobe high on cycles 1..8; done = 1 on cycle 9; tx_ready = 1 on cycle 10.
- Slow bit period: C = 4, pdatain = 8'hA5.
  -> each bit held for 4 cycles; sstrobe on cycles 4, 8, …, 32; done on cycle 33; busy high on cycles 1..32.
- Loopback: transmitter drives a shift_register (n = 8, shift = sstrobe, sdatain = sdataout), send 8'h3C.
  -> receiver pdataout == 8'h3C on the cycle after done.
- LSB-first: MSB_FIRST = 0, pdatain = 8'b00000001.
  -> sdataout = 1 in bit 0, then seven 0s.
- Busy-phase request: tx_valid held high with pdatain changed to 8'hFF mid-frame of 8'h0F.
  -> first frame sends 8'h0F unaltered; 8'hFF is accepted in the first cycle tx_ready returns, i.e. cycle 10 for C = 1.
- Reset mid-frame: n_reset low at cycle 4 of an 8-bit frame.
  -> next edge: sdataout = 0, busy = 0, done never pulses; tx_ready = 1 on the first cycle with n_reset = 1.
